// File: rtl/imem_loader.sv
// Byte-stream program loader for the MIPS core's instruction memory.
// Accepts a count/payload/checksum frame, writes big-endian words and releases the core when the checksum verifies.
module imem_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_rst_n,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    state_t              state_q;
    logic [ADDR_W-1:0]   last_idx_q;
    logic [ADDR_W-1:0]   word_idx_q;
    logic [1:0]          byte_idx_q;
    logic [23:0]         asm_q;
    logic [7:0]          xor_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [31:0]         wr_data_q;
    logic                cpu_rst_n_q;
    logic                done_q;
    logic                err_q;

    logic                take;
    logic                count_ok_d;
    logic [31:0]         word_d;
    logic [7:0]          xor_d;
    logic                last_word_d;

    // Held low during reset so nothing is accepted on the reset edge itself.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            in_ready = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_CHK);
        end
    end

    always_comb begin
        take        = in_valid & in_ready;
        count_ok_d  = (in_data != 8'd0) && (in_data <= DEPTH_B);
        word_d      = {asm_q, in_data};
        xor_d       = xor_q ^ in_data;
        last_word_d = (word_idx_q == last_idx_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_idx_q  <= '0;
            word_idx_q  <= '0;
            byte_idx_q  <= '0;
            asm_q       <= '0;
            xor_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            cpu_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (take) begin
                        if (count_ok_d) begin
                            // Count is 1..DEPTH, so count-1 always fits the address width.
                            last_idx_q <= ADDR_W'(in_data - 8'd1);
                            word_idx_q <= '0;
                            byte_idx_q <= '0;
                            xor_q      <= '0;
                            state_q    <= S_DATA;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= S_ERR;
                        end
                    end
                end
                S_DATA: begin
                    if (take) begin
                        asm_q      <= word_d[23:0];
                        xor_q      <= xor_d;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            wr_en_q    <= 1'b1;
                            wr_addr_q  <= word_idx_q;
                            wr_data_q  <= word_d;
                            if (last_word_d) begin
                                state_q <= S_CHK;
                            end else begin
                                word_idx_q <= word_idx_q + 1'b1;
                            end
                        end
                    end
                end
                S_CHK: begin
                    if (take) begin
                        if (in_data == xor_q) begin
                            done_q      <= 1'b1;
                            cpu_rst_n_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= S_ERR;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                S_ERR: begin
                    state_q <= S_ERR;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign cpu_rst_n = cpu_rst_n_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected writes, a negedge monitor checks them.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cpu_rst_n;
    logic        done;
    logic        err;

    imem_loader #(.DEPTH(64), .ADDR_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_rst_n (cpu_rst_n),
        .done      (done),
        .err       (err)
    );

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_exp_t;

    wr_exp_t     exp_q[$];
    logic [31:0] img [64];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: every write strobe must match the head of the expected queue, in the expected cycle.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write (cycle %0d)",
                         wr_addr, wr_data, cyc);
            end else begin
                wr_exp_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.addr));
                check("wr_data", wr_data, e.data);
                check("wr_cycle", 32'(cyc), 32'(e.cyc));
                $display("write addr=%0d data=0x%08h cycle=%0d", wr_addr, wr_data, cyc);
            end
        end
    end

    // Drive one byte starting #1 after an edge; returns the cycle count right after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int max_gap, output int acc_cyc);
        bit ok;
        int waited;
        if (max_gap > 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, max_gap)) begin
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        waited   = 0;
        acc_cyc  = -1;
        forever begin
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) begin
                acc_cyc = cyc;
                break;
            end
            waited++;
            if (waited > 100) begin
                n_checks++;
                $display("FAIL accept_timeout: byte 0x%02h not accepted within 100 cycles", b);
                break;
            end
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    // Sends count, payload from img[], then checksum; stop_after >= 0 aborts after that many payload bytes.
    task automatic send_frame(input logic [7:0] cnt, input int nwords, input logic [7:0] chk_byte,
                              input int max_gap, input int stop_after);
        int acc;
        int nb;
        send_byte(cnt, max_gap, acc);
        $display("count byte 0x%02h accepted at cycle %0d", cnt, acc);
        if (nwords == 0) return;
        nb = 0;
        for (int w = 0; w < nwords; w++) begin
            for (int k = 3; k >= 0; k--) begin
                logic [31:0] word;
                word = img[w];
                send_byte(word[8*k +: 8], max_gap, acc);
                nb++;
                if (k == 0) begin
                    wr_exp_t e;
                    e.addr = 6'(w);
                    e.data = img[w];
                    e.cyc  = acc;
                    exp_q.push_back(e);
                end
                if (nb == stop_after) return;
            end
        end
        check("cpu_rst_n_loading", 32'(cpu_rst_n), 32'd0);
        check("done_loading", 32'(done), 32'd0);
        send_byte(chk_byte, max_gap, acc);
        $display("checksum byte 0x%02h accepted at cycle %0d", chk_byte, acc);
    endtask

    task automatic status(input string tag, input logic d, input logic e, input logic c, input logic r);
        check({tag, "_done"}, 32'(done), 32'(d));
        check({tag, "_err"}, 32'(err), 32'(e));
        check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(c));
        check({tag, "_in_ready"}, 32'(in_ready), 32'(r));
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_data  = 8'h00;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        status("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic drain(input string tag);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int acc;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #1;

        // Normal two-word load, back to back; checksum 20^01^00^05 = 24.
        do_reset();
        img[0] = 32'h2001_0005;
        img[1] = 32'h0000_0000;
        send_frame(8'h02, 2, 8'h24, 0, -1);
        status("normal", 1'b1, 1'b0, 1'b1, 1'b0);
        // DONE is terminal: further bytes are refused and produce no writes.
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        status("done_hold", 1'b1, 1'b0, 1'b1, 1'b0);
        drain("normal");

        // Bad checksum: both writes still happen, then ERR forever.
        do_reset();
        send_frame(8'h02, 2, 8'h25, 0, -1);
        status("badchk", 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        status("badchk_hold", 1'b0, 1'b1, 1'b0, 1'b0);
        drain("badchk");

        // Bad counts 0 and 65.
        do_reset();
        send_frame(8'h00, 0, 8'h00, 0, -1);
        status("count0", 1'b0, 1'b1, 1'b0, 1'b0);
        drain("count0");
        do_reset();
        send_frame(8'h41, 0, 8'h00, 0, -1);
        status("count65", 1'b0, 1'b1, 1'b0, 1'b0);
        drain("count65");

        // Full depth: A5 appears 64 times and 0..63 XOR to zero, so checksum is 0x00.
        do_reset();
        for (int k = 0; k < 64; k++) img[k] = 32'hA500_0000 | 32'(k);
        send_frame(8'h40, 64, 8'h00, 0, -1);
        status("full", 1'b1, 1'b0, 1'b1, 1'b0);
        drain("full");

        // Two-word frame with 1-3 idle cycles between bytes.
        do_reset();
        img[0] = 32'h2001_0005;
        img[1] = 32'h0000_0000;
        send_frame(8'h02, 2, 8'h24, 3, -1);
        status("gaps", 1'b1, 1'b0, 1'b1, 1'b0);
        drain("gaps");

        // Reset after the 6th payload byte: only word 0 is written, then a fresh frame loads.
        do_reset();
        send_frame(8'h02, 2, 8'h24, 0, 6);
        do_reset();
        check("midrst_pending_writes", 32'(exp_q.size()), 32'd0);
        send_frame(8'h02, 2, 8'h24, 0, -1);
        status("midrst_reload", 1'b1, 1'b0, 1'b1, 1'b0);
        drain("midrst");

        // Single-word frame with a byte offered while idle in DONE check skipped; minimal N=1.
        do_reset();
        img[0] = 32'h1234_5678;
        send_frame(8'h01, 1, 8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78, 0, -1);
        status("n1", 1'b1, 1'b0, 1'b1, 1'b0);
        drain("n1");

        acc = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader for the 64-word instruction memory of the single-cycle MIPS core. It writes the instruction memory that the core only reads: it accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Each word is written through a one-cycle write strobe. The core is held in reset (`cpu_rst_n` low) until the whole image has been received and its checksum verified.

## Interface
- `DEPTH`, 64: instruction memory depth in words; the maximum word count the loader accepts.
- `ADDR_W`, 6: word address width, equal to the width of the core's `pc[5:0]` instruction address.
- `clk`, in, 1: single system clock.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: source presents a byte on `in_data`.
- `in_data`, in, 8: stream byte.
- `in_ready`, out, 1: loader accepts the byte this cycle. A transfer occurs when `in_valid & in_ready`.
- `wr_en`, out, 1: instruction memory write strobe, one cycle per word.
- `wr_addr`, out, ADDR_W: word address for the write.
- `wr_data`, out, 32: word to write.
- `cpu_rst_n`, out, 1: active-low reset to the core; high only after a successful load.
- `done`, out, 1: image loaded and verified.
- `err`, out, 1: framing or checksum failure.

## Operation
- Frame layout, in order:
  - count byte N, where 1 ≤ N ≤ DEPTH;
  - 4·N payload bytes, most significant byte of each word first;
  - one checksum byte equal to the XOR of all payload bytes. The count byte is not included in the checksum.
- State machine `IDLE → DATA → CHK → DONE`, plus `ERR`.
- **IDLE** (`in_ready`=1):
  - On a transfer, N = `in_data` is latched.
  - N = 0 or N > DEPTH goes to ERR.
  - Otherwise go to DATA; the word index, byte index and XOR accumulator are cleared.
- **DATA** (`in_ready`=1):
  - Each transfer shifts the byte into a 32-bit assembly register, XORs it into the accumulator and increments the 2-bit byte index.
  - The cycle after the 4th byte of a word is accepted: `wr_en`=1, `wr_addr`=word index, `wr_data`=assembled word. The word index then increments.
  - After the 4th byte of word N−1 is accepted, go to CHK.
- **CHK** (`in_ready`=1):
  - On a transfer, compare `in_data` with the accumulator. Equal goes to DONE; unequal goes to ERR.
- **DONE**:
  - `in_ready`=0, `done`=1, `cpu_rst_n`=1.
  - Terminal until `rst`.
- **ERR**:
  - `in_ready`=0, `err`=1, `cpu_rst_n`=0.
  - Terminal until `rst`.
  - Words already written are not retracted.
- `cpu_rst_n` is 0 in every state except DONE.
- `done` and `err` are never both 1.
- Bytes presented with `in_valid`=0 are ignored. Cycles with `in_valid`=0 insert no extra writes and leave no state advanced.

## Timing
- **Reset values:** state IDLE, `in_ready`=0 while `rst`=1, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `cpu_rst_n`=0, `done`=0, `err`=0.
- **First acceptance:** `in_ready`=1 from the first cycle after `rst` deasserts.
- **Outputs:** all outputs except `in_ready` are registered. `in_ready` is a decode of the state register, with no combinational path from `in_valid`.
- **Write latency:** `wr_en` rises exactly 1 cycle after the accepting edge of a word's 4th byte and lasts 1 cycle. `wr_addr` and `wr_data` are stable during that cycle.
- **Throughput:** one byte per cycle. A byte may be accepted in the same cycle that `wr_en` is high. For the last word, `wr_en` coincides with the first CHK cycle, and the checksum byte may be accepted in that cycle.
- **Status latency:** `done` or `err` rises 1 cycle after the accepting edge of the checksum byte, or of a bad count byte. `cpu_rst_n` rises in the same cycle as `done`.
- **Address range:** `wr_addr` spans 0..N−1 and never wraps. With N = DEPTH, the last write goes to address 63.
- **Reset mid-frame:** `rst`=1 in any state returns the loader to IDLE on that edge. Partial word, accumulator and indices are discarded. `wr_en`, `done` and `err` are 0 and `cpu_rst_n`=0 on the next cycle.
- **Reset during write:** `rst` in the same cycle as a pending write suppresses that write.

## Test plan
- **Normal two-word load:** stream 0x02, 0x20 0x01 0x00 0x05, 0x00 0x00 0x00 0x00, 0x24 back-to-back.
  - Writes (0, 0x20010005) and (1, 0x00000000).
  - `done`=1 and `cpu_rst_n`=1 one cycle after 0x24; `err`=0.
- **Bad checksum:** same frame with checksum 0x25.
  - Both writes occur.
  - `err`=1, `done`=0; `cpu_rst_n` stays 0 indefinitely; `in_ready`=0.
- **Bad count:** count byte 0x00 → `err`=1 next cycle, no `wr_en`. Repeat after `rst` with 0x41 (65) → same response.
- **Full-depth load:** N=0x40, word k = 0xA5000000|k, with the correct checksum.
  - 64 writes at addresses 0..63 in order; last `wr_data`=0xA500003F.
  - `done`=1.
- **Backpressure gaps:** the two-word frame with `in_valid` low for 1–3 random cycles between bytes.
  - Identical writes and final status to the back-to-back case; each write comes 1 cycle after its 4th byte.
- **Reset mid-load:** assert `rst` after the 6th payload byte of a 2-word frame.
  - No second write.
  - After reset, a fresh full frame loads correctly and ends in `done`=1.
